// File: rtl/lcd_frame_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_frame_arbiter
//
// Shares the single LCD character-buffer write port between two frame
// sources (e.g. measurement readout and settings menu). A granted source
// has its whole frame of NCHAR characters fetched by address and written
// into the LCD buffer. A repaint is then triggered, and the arbiter waits
// for the LCD busy cycle to end before it serves another request.
// Arbitration is round-robin on ties.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   req[1:0]     in   level-sensitive frame request per source
//   gnt[1:0]     out  one-hot grant, held for the whole frame
//   done[1:0]    out  one-cycle pulse to the served source at frame end
//   rd_addr[4:0] out  character index requested from the granted source
//   rd_en        out  rd_addr valid this cycle
//   rd_data0[7:0] in  source 0 character, valid one cycle after rd_en
//   rd_data1[7:0] in  source 1 character, valid one cycle after rd_en
//   lcd_dat[7:0] out  character to the LCD buffer
//   lcd_addr[4:0] out LCD buffer address
//   lcd_we       out  LCD buffer write strobe
//   lcd_repaint  out  one-cycle repaint pulse
//   lcd_busy     in   LCD controller busy
// ---------------------------------------------------------------------------
module lcd_frame_arbiter #(
    parameter int NCHAR   = 32,
    parameter int RISE_TO = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [4:0] rd_addr,
    output logic       rd_en,
    input  logic [7:0] rd_data0,
    input  logic [7:0] rd_data1,
    output logic [7:0] lcd_dat,
    output logic [4:0] lcd_addr,
    output logic       lcd_we,
    output logic       lcd_repaint,
    input  logic       lcd_busy
);

    localparam int              TMO_W     = $clog2(RISE_TO + 1);
    localparam logic [4:0]       LAST_ADDR = 5'(NCHAR - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(RISE_TO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_REPAINT,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       gnt_q,   gnt_d;
    logic             last_q,  last_d;   // index of the source served last
    logic [4:0]       cnt_q,   cnt_d;    // fetch address counter
    logic [TMO_W-1:0] tmo_q,   tmo_d;    // busy-rise timeout counter
    logic             we_q;              // rd_en delayed by one cycle
    logic [4:0]       waddr_q;           // rd_addr delayed by one cycle
    logic [1:0]       pick;

    // Round-robin choice: on a tie, serve the source not served last.
    // A single request is already one-hot.
    assign pick = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values. Reset is synchronous, so it is only tested on the
    // clock edge and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            // The write stage trails the fetch stage by exactly one cycle.
            // rd_addr is forced to 0 outside FETCH, so lcd_addr idles at 0.
            we_q    <= rd_en;
            waddr_q <= rd_addr;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a hold default before the case statement, so
    // no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if ((|req) && !lcd_busy) begin
                    gnt_d   = pick;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_FLUSH: begin
                // The last character is written this cycle.
                state_d = S_REPAINT;
            end
            S_REPAINT: begin
                tmo_d   = '0;
                state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                // If busy never rises, the controller missed the repaint.
                // Give up after RISE_TO+1 cycles.
                if (lcd_busy) begin
                    state_d = S_WAIT_FALL;
                end else if (tmo_q == TMO_MAX) begin
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_FALL: begin
                if (!lcd_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        gnt         = gnt_q;
        rd_en       = (state_q == S_FETCH);
        rd_addr     = rd_en ? cnt_q : 5'd0;
        lcd_repaint = (state_q == S_REPAINT);
        done        = (state_q == S_DONE) ? gnt_q : 2'b00;
        lcd_we      = we_q;
        lcd_addr    = waddr_q;
        // Source data arrives one cycle after rd_en. It is passed through
        // unregistered, so it lines up with the delayed address.
        lcd_dat     = 8'h00;
        if (we_q) begin
            lcd_dat = gnt_q[1] ? rd_data1 : rd_data0;
        end
    end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_frame_arbiter
//
// Directed testbench for lcd_frame_arbiter. Two character sources answer
// one cycle after rd_en: source 0 with 0x41+addr, source 1 with 0xC0+addr.
// Each frame is compared cycle by cycle against offsets from the grant
// cycle, and all expected values are computed here.
// ---------------------------------------------------------------------------
module tb_lcd_frame_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [4:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data0;
    logic [7:0] rd_data1;
    logic [7:0] lcd_dat;
    logic [4:0] lcd_addr;
    logic       lcd_we;
    logic       lcd_repaint;
    logic       lcd_busy;

    int n_vec = 0;
    int n_bad = 0;

    lcd_frame_arbiter #(
        .NCHAR  (32),
        .RISE_TO(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data0   (rd_data0),
        .rd_data1   (rd_data1),
        .lcd_dat    (lcd_dat),
        .lcd_addr   (lcd_addr),
        .lcd_we     (lcd_we),
        .lcd_repaint(lcd_repaint),
        .lcd_busy   (lcd_busy)
    );

    initial forever #5 clk = ~clk;

    // Character sources: return the character for the address requested
    // one cycle earlier.
    logic [4:0] src_addr_q = 5'd0;
    always @(posedge clk) src_addr_q <= rd_addr;
    assign rd_data0 = 8'h41 + {3'b000, src_addr_q};
    assign rd_data1 = 8'hC0 + {3'b000, src_addr_q};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] src_char(input logic [1:0] g, input int a);
        return g[1] ? (8'hC0 + 8'(a)) : (8'h41 + 8'(a));
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        req      = 2'b00;
        lcd_busy = 1'b0;
        tick();
        tick();
        check("reset outputs",
              32'({gnt, done, rd_en, rd_addr, lcd_we, lcd_addr, lcd_dat, lcd_repaint}), 32'd0);
        reset = 1'b0;
    endtask

    // Tick until a grant appears, within max_wait cycles. Check which source
    // was granted and how many cycles it took.
    task automatic wait_gnt(input logic [1:0] g, input int exp_lat, input int max_wait);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 2'b00 && n < max_wait);
        check("grant", 32'(gnt), 32'(g));
        check("grant latency", 32'(n), 32'(exp_lat));
    endtask

    // Check one whole frame, starting in the grant cycle (offset c=1).
    // rise < 0 : busy stays low, so the timeout path is taken.
    // rise >= 0: busy is high from offset 34+rise for blen cycles.
    // drop_c   : offset at which req is released (0 = never).
    task automatic run_frame(input logic [1:0] g, input int rise, input int blen, input int drop_c);
        int          done_c;
        logic        we_e;
        logic [4:0]  ra_e;
        logic [4:0]  wa_e;
        logic [7:0]  d_e;
        logic [24:0] exp_v;
        logic [24:0] got_v;
        done_c = (rise < 0) ? 51 : (34 + rise + blen + 1);
        for (int c = 1; c <= done_c + 1; c++) begin
            if (c > 1) tick();
            if (c == drop_c) req = 2'b00;
            lcd_busy = (rise >= 0) && (c >= 34 + rise) && (c < 34 + rise + blen);
            ra_e  = (c <= 32) ? 5'(c - 1) : 5'd0;
            we_e  = (c >= 2) && (c <= 33);
            wa_e  = we_e ? 5'(c - 2) : 5'd0;
            d_e   = we_e ? src_char(g, c - 2) : 8'h00;
            exp_v = {(c <= done_c) ? g : 2'b00, (c == done_c) ? g : 2'b00,
                     (c == 34), (c <= 32), ra_e, we_e, wa_e, d_e};
            got_v = {gnt, done, lcd_repaint, rd_en, rd_addr, lcd_we, lcd_addr, lcd_dat};
            check($sformatf("frame g=%b c=%0d", g, c), 32'(got_v), 32'(exp_v));
        end
    endtask

    initial begin
        logic [3:0] seen;
        reset    = 1'b1;
        req      = 2'b00;
        lcd_busy = 1'b0;

        do_reset();

        // Single frame from source 0, busy pulse of 100 cycles.
        req = 2'b01;
        wait_gnt(2'b01, 1, 4);
        run_frame(2'b01, 3, 100, 0);
        req = 2'b00;
        tick();
        check("idle after single", 32'(gnt), 32'd0);

        // Both sources request continuously: 01, 10, 01.
        do_reset();
        req = 2'b11;
        wait_gnt(2'b01, 1, 4);
        run_frame(2'b01, 2, 5, 0);
        wait_gnt(2'b10, 1, 4);
        run_frame(2'b10, 2, 5, 0);
        wait_gnt(2'b01, 1, 4);
        run_frame(2'b01, 2, 5, 1);
        tick();
        check("no regrant after tie", 32'(gnt), 32'd0);

        // Busy in IDLE blocks a grant. Then a repaint timeout on source 1.
        lcd_busy = 1'b1;
        req      = 2'b10;
        repeat (50) tick();
        check("blocked by busy", 32'(gnt), 32'd0);
        lcd_busy = 1'b0;
        wait_gnt(2'b10, 1, 4);
        run_frame(2'b10, -1, 0, 1);

        // Next frame proceeds normally, with req dropped at fetch address 10.
        req = 2'b01;
        wait_gnt(2'b01, 1, 4);
        run_frame(2'b01, 4, 6, 11);
        tick();
        check("idle after drop", 32'(gnt), 32'd0);

        // Reset at fetch address 20: everything goes quiet, with no repaint.
        req = 2'b01;
        wait_gnt(2'b01, 1, 4);
        repeat (20) tick();
        check("fetch addr before reset",
              32'({rd_en, rd_addr, lcd_we, lcd_addr}), 32'({1'b1, 5'd20, 1'b1, 5'd19}));
        reset = 1'b1;
        req   = 2'b00;
        tick();
        check("outputs after reset", 32'({gnt, lcd_we, rd_en, lcd_repaint}), 32'd0);
        reset = 1'b0;
        seen  = 4'h0;
        repeat (60) begin
            tick();
            seen |= {lcd_we, lcd_repaint, |gnt, |done};
        end
        check("quiet after reset", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
